// File: rtl/vm_xlate_arbiter.sv
// vm_xlate_arbiter: round-robin arbiter in front of the page table block.
// Grants one translation request at a time, looks the VPN up in the live
// page table and returns the physical address (or a fault) on a valid/ready
// response channel. Keeps a saturating count of delivered faults.
// Optional build macro XLATE_FAULT_RETRY_EN: an in-range but invalid entry
// is re-polled for up to RETRY_MAX cycles before the request faults.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a request; grants one requester per visit
// ST_LOOKUP  | reads pt_entry for the latched VPN, latches the result
// ST_RETRY   | (retry build only) re-reads an invalid entry each cycle
// ST_RESP    | response held on rsp_*; leaves on rsp_valid && rsp_ready
module vm_xlate_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_VPAGES = 8,
  parameter int PAGE_BITS  = 12,
  parameter int RETRY_MAX  = 255
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0][31:0]   req_vaddr,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [31:0]                rsp_paddr,
  output logic                       rsp_fault,
  input  logic                       rsp_ready,
  input  logic [NUM_VPAGES-1:0][3:0] pt_entry,
  output logic [15:0]                fault_count
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int VPN_W = 32 - PAGE_BITS;
  localparam int IDX_W = (NUM_VPAGES > 1) ? $clog2(NUM_VPAGES) : 1;
  localparam logic [VPN_W-1:0] VPN_LIMIT = VPN_W'(NUM_VPAGES);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
`ifdef XLATE_FAULT_RETRY_EN
  localparam int RETRY_W = $clog2(RETRY_MAX + 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_MAX - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_RESP
`ifdef XLATE_FAULT_RETRY_EN
    , ST_RETRY
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [31:0]       vaddr_q, vaddr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_paddr_q, rsp_paddr_d;
  logic              rsp_fault_q, rsp_fault_d;
  logic [15:0]       fault_count_q, fault_count_d;
`ifdef XLATE_FAULT_RETRY_EN
  logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
`endif

  logic              rr_found;
  logic [ID_W-1:0]   rr_pick;
  logic [VPN_W-1:0]  vpn;
  logic              in_range;
  logic [3:0]        entry;
  logic [31:0]       xlate_paddr;

  // Page table lookup for the latched request; entry is only trusted when in range.
  assign vpn      = vaddr_q[31:PAGE_BITS];
  assign in_range = (vpn < VPN_LIMIT);
  assign entry    = pt_entry[vpn[IDX_W-1:0]];

  // Physical address: PPN placed directly above the page offset, zero-extended.
  always_comb begin
    xlate_paddr = '0;
    xlate_paddr[PAGE_BITS+2:0] = {entry[3:1], vaddr_q[PAGE_BITS-1:0]};
  end

  // Round-robin search over req_valid starting at rr_ptr.
  always_comb begin : rr_search
    int cand;
    rr_found = 1'b0;
    rr_pick  = '0;
    cand     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!rr_found && req_valid[ID_W'(cand)]) begin
        rr_found = 1'b1;
        rr_pick  = ID_W'(cand);
      end
    end
  end

  // Next-state and datapath for the translation sequencer.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    vaddr_d       = vaddr_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_paddr_d   = rsp_paddr_q;
    rsp_fault_d   = rsp_fault_q;
    fault_count_d = fault_count_q;
`ifdef XLATE_FAULT_RETRY_EN
    retry_cnt_d   = retry_cnt_q;
`endif
    req_ready     = '0;
    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          req_ready[rr_pick] = 1'b1;
          grant_d            = rr_pick;
          vaddr_d            = req_vaddr[rr_pick];
          state_d            = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (in_range && entry[0]) begin
          rsp_valid_d = 1'b1;
          rsp_paddr_d = xlate_paddr;
          rsp_fault_d = 1'b0;
          state_d     = ST_RESP;
        end else if (!in_range) begin
          rsp_valid_d = 1'b1;
          rsp_paddr_d = '0;
          rsp_fault_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
`ifdef XLATE_FAULT_RETRY_EN
          retry_cnt_d = '0;
          state_d     = ST_RETRY;
`else
          rsp_valid_d = 1'b1;
          rsp_paddr_d = '0;
          rsp_fault_d = 1'b1;
          state_d     = ST_RESP;
`endif
        end
      end
`ifdef XLATE_FAULT_RETRY_EN
      ST_RETRY: begin
        if (entry[0]) begin
          rsp_valid_d = 1'b1;
          rsp_paddr_d = xlate_paddr;
          rsp_fault_d = 1'b0;
          state_d     = ST_RESP;
        end else if (retry_cnt_q == RETRY_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_paddr_d = '0;
          rsp_fault_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          retry_cnt_d = retry_cnt_q + 1'b1;
        end
      end
`endif
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
          if (rsp_fault_q && (fault_count_q != 16'hFFFF))
            fault_count_d = fault_count_q + 16'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      vaddr_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_paddr_q   <= '0;
      rsp_fault_q   <= 1'b0;
      fault_count_q <= '0;
`ifdef XLATE_FAULT_RETRY_EN
      retry_cnt_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      vaddr_q       <= vaddr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_paddr_q   <= rsp_paddr_d;
      rsp_fault_q   <= rsp_fault_d;
      fault_count_q <= fault_count_d;
`ifdef XLATE_FAULT_RETRY_EN
      retry_cnt_q   <= retry_cnt_d;
`endif
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = grant_q;
  assign rsp_paddr   = rsp_paddr_q;
  assign rsp_fault   = rsp_fault_q;
  assign fault_count = fault_count_q;

endmodule

// File: tb/tb_vm_xlate_arbiter.sv
// Testbench for vm_xlate_arbiter: directed requests, expectations queued at
// grant time and compared by a response monitor on each handshake.
module tb_vm_xlate_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int NUM_VPAGES = 8;

  logic                       CLK;
  logic                       nRST;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0][31:0]   req_vaddr;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       rsp_valid;
  logic [1:0]                 rsp_id;
  logic [31:0]                rsp_paddr;
  logic                       rsp_fault;
  logic                       rsp_ready;
  logic [NUM_VPAGES-1:0][3:0] pt_entry;
  logic [15:0]                fault_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          id;
    logic [31:0] pa;
    logic        f;
  } exp_t;
  exp_t exp_q[$];

  vm_xlate_arbiter #(
    .NUM_REQ(NUM_REQ), .NUM_VPAGES(NUM_VPAGES), .PAGE_BITS(12), .RETRY_MAX(255)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_vaddr(req_vaddr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_paddr(rsp_paddr),
    .rsp_fault(rsp_fault), .rsp_ready(rsp_ready),
    .pt_entry(pt_entry), .fault_count(fault_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Response monitor: pops one expectation per handshake.
  always @(negedge CLK) begin
    if (nRST && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp actual id=%0d paddr=0x%08h required none", rsp_id, rsp_paddr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (int'(rsp_id) != e.id || rsp_paddr !== e.pa || rsp_fault !== e.f) begin
          failures++;
          $display("FAIL rsp actual id=%0d paddr=0x%08h fault=%0b required id=%0d paddr=0x%08h fault=%0b",
                   rsp_id, rsp_paddr, rsp_fault, e.id, e.pa, e.f);
        end
      end
    end
  end

  // Grant strobe must be at most one-hot.
  always @(negedge CLK) begin
    if (nRST) begin
      checks++;
      if ($countones(req_ready) > 1) begin
        failures++;
        $display("FAIL req_ready_onehot actual=%b required at most one bit", req_ready);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Raise one request, wait for its grant, optionally queue the expected response.
  task automatic issue(input int id, input logic [31:0] va, input logic [31:0] exp_pa,
                       input logic exp_f, input bit push);
    bit got;
    got = 1'b0;
    req_vaddr[id] = va;
    req_valid[id] = 1'b1;
    for (int n = 0; n < 600 && !got; n++) begin
      @(negedge CLK);
      if (req_ready[id]) got = 1'b1;
      tick();
    end
    req_valid[id] = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL grant_timeout id=%0d actual=no grant required=grant", id);
    end else if (push) begin
      exp_q.push_back('{id, exp_pa, exp_f});
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 600 && !done; n++) begin
      tick();
      if (exp_q.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout actual pending=%0d required=0", exp_q.size());
    end
  endtask

  initial begin
    int rr_log[5];
    int rr_exp[5];
    int ng;
    bool_stable_blk: begin end
    rr_exp    = '{0, 1, 2, 3, 0};
    nRST      = 1'b0;
    req_valid = '0;
    req_vaddr = '0;
    rsp_ready = 1'b1;
    pt_entry  = '0;
    pt_entry[2] = 4'b1011;
    #1;
    check("reset_rsp_valid",   32'(rsp_valid),   32'd0);
    check("reset_req_ready",   32'(req_ready),   32'd0);
    check("reset_rsp_id",      32'(rsp_id),      32'd0);
    check("reset_rsp_paddr",   rsp_paddr,        32'd0);
    check("reset_rsp_fault",   32'(rsp_fault),   32'd0);
    check("reset_fault_count", 32'(fault_count), 32'd0);
    repeat (2) tick();
    nRST = 1'b1;
    tick();

    // Round-robin with every requester asserting continuously.
    for (int k = 0; k < NUM_REQ; k++) req_vaddr[k] = 32'h0000_2000 | (k << 4);
    req_valid = '1;
    ng = 0;
    for (int cyc = 0; cyc < 60 && ng < 5; cyc++) begin
      @(negedge CLK);
      if (req_ready != '0) begin
        int g;
        g = 0;
        for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) g = k;
        rr_log[ng] = g;
        exp_q.push_back('{g, 32'h0000_5000 | (g << 4), 1'b0});
        ng++;
      end
      tick();
    end
    req_valid = '0;
    check("rr_grant_count", 32'(ng), 32'd5);
    for (int i = 0; i < 5; i++) check($sformatf("rr_grant_%0d", i), 32'(rr_log[i]), 32'(rr_exp[i]));
    wait_drain();

    // Basic hit with latency: accept in N, rsp_valid in N+2.
    req_vaddr[1] = 32'h0000_2ABC;
    req_valid[1] = 1'b1;
    @(negedge CLK);
    check("hit_req_ready", 32'(req_ready), 32'b0010);
    exp_q.push_back('{1, 32'h0000_5ABC, 1'b0});
    tick();
    req_valid[1] = 1'b0;
    check("hit_rsp_valid_n1", 32'(rsp_valid), 32'd0);
    tick();
    check("hit_rsp_valid_n2", 32'(rsp_valid), 32'd1);
    wait_drain();

    // Out-of-range VPN faults with a zero address.
    issue(2, 32'h0000_8000, 32'h0, 1'b1, 1'b1);
    wait_drain();
    check("fault_count_oor", 32'(fault_count), 32'd1);

    // In-range invalid entry faults.
    pt_entry[3] = 4'b0110;
    issue(3, 32'h0000_3123, 32'h0, 1'b1, 1'b1);
    wait_drain();
    check("fault_count_inv", 32'(fault_count), 32'd2);

    // Backpressure: response held, page table change ignored, no grants, withdrawal.
    rsp_ready = 1'b0;
    issue(0, 32'h0000_2ABC, 32'h0000_5ABC, 1'b0, 1'b1);
    tick();
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    pt_entry[2]  = 4'b0000;
    req_vaddr[1] = 32'h0000_2000;
    req_valid[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      check($sformatf("bp_hold_paddr_%0d", c), rsp_paddr, 32'h0000_5ABC);
      check($sformatf("bp_hold_ctl_%0d", c), {rsp_valid, rsp_fault, 26'd0, req_ready},
            {1'b1, 1'b0, 26'd0, 4'b0000});
      tick();
    end
    req_valid[1] = 1'b0;
    rsp_ready    = 1'b1;
    wait_drain();
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check($sformatf("withdraw_idle_%0d", c), {31'd0, rsp_valid} | 32'(req_ready), 32'd0);
      tick();
    end
    pt_entry[2] = 4'b1011;

`ifdef XLATE_FAULT_RETRY_EN
    // Entry becomes valid while retrying.
    pt_entry[4] = 4'b0000;
    issue(0, 32'h0000_4DEF, 32'h0000_3DEF, 1'b0, 1'b1);
    repeat (5) tick();
    pt_entry[4] = 4'b0111;
    wait_drain();
    // Entry stays invalid: fault after the retry limit.
    pt_entry[4] = 4'b0000;
    issue(1, 32'h0000_4000, 32'h0, 1'b1, 1'b1);
    wait_drain();
    check("fault_count_retry", 32'(fault_count), 32'd3);
`endif

    // Reset while a response is pending: dropped, counters cleared.
    rsp_ready = 1'b0;
    issue(2, 32'h0000_2111, 32'h0, 1'b0, 1'b0);
    tick();
    check("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    check("mid_reset_rsp_valid",   32'(rsp_valid),   32'd0);
    check("mid_reset_fault_count", 32'(fault_count), 32'd0);
    check("mid_reset_rsp_paddr",   rsp_paddr,        32'd0);
    tick();
    nRST      = 1'b1;
    rsp_ready = 1'b1;
    tick();
    req_vaddr[0] = 32'h0000_2456;
    req_vaddr[1] = 32'h0000_2789;
    req_valid    = 4'b0011;
    @(negedge CLK);
    check("post_reset_grant", 32'(req_ready), 32'b0001);
    if (req_ready[0]) exp_q.push_back('{0, 32'h0000_5456, 1'b0});
    tick();
    req_valid = '0;
    wait_drain();

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
